// File: rtl/jk_pkg.sv
// Shared encodings for the JK latch-bank driver: request ops, FSM states and j/k pair codes.
package jk_pkg;

    localparam int unsigned JK_STATE_W = 3;
    localparam int unsigned JK_PAIR_W  = 2;

    localparam logic JK_OP_WRITE  = 1'b0;
    localparam logic JK_OP_TOGGLE = 1'b1;

    localparam logic [JK_STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [JK_STATE_W-1:0] ST_SETUP  = 3'd1;
    localparam logic [JK_STATE_W-1:0] ST_STROBE = 3'd2;
    localparam logic [JK_STATE_W-1:0] ST_HOLD   = 3'd3;
    localparam logic [JK_STATE_W-1:0] ST_CHECK  = 3'd4;

    // {j,k} pair codes; 2'b11 would make a transparent latch oscillate
    localparam logic [JK_PAIR_W-1:0] JK_HOLD    = 2'b00;
    localparam logic [JK_PAIR_W-1:0] JK_RST     = 2'b01;
    localparam logic [JK_PAIR_W-1:0] JK_SET     = 2'b10;
    localparam logic [JK_PAIR_W-1:0] JK_ILLEGAL = 2'b11;

endpackage

// File: rtl/jk_excite.sv
// Per-cell JK excitation: minimal {j,k} pair moving a cell from cur to target.
module jk_excite
    import jk_pkg::*;
(
    input  logic                 cur,
    input  logic                 target,
    output logic [JK_PAIR_W-1:0] jk_c
);

    always_comb begin
        jk_c = JK_HOLD;
        if (cur != target) begin
            jk_c = target ? JK_SET : JK_RST;
        end
    end

    always_comb begin
        assert (jk_c != JK_ILLEGAL) else $error("jk_excite: illegal j=k=1 pair");
    end

endmodule

// File: rtl/jk_bank_driver.sv
// Initiator for a bank of JK latch cells: excites j/k, pulses en, then verifies q feedback.
module jk_bank_driver
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned PULSE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_op,
    input  logic [WIDTH-1:0] req_data,
    output logic             req_ready,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             en,
    output logic             done,
    output logic             fail,
    output logic [WIDTH-1:0] expected
);

    localparam int unsigned CNT_W = (PULSE > 1) ? $clog2(PULSE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PULSE - 1);

    logic [JK_STATE_W-1:0] state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [WIDTH-1:0]      j_nxt, k_nxt, expected_nxt;
    logic                  en_nxt, done_nxt, fail_nxt, ready_nxt;

    logic [WIDTH-1:0]      target_c;
    logic [WIDTH-1:0]      exc_j_c, exc_k_c;

    // Bank is never enabled in IDLE, so q_fb at the accept edge is the SETUP snapshot
    assign target_c = (req_op == JK_OP_TOGGLE) ? (q_fb ^ req_data) : req_data;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_excite
        logic [JK_PAIR_W-1:0] pair_c;
        jk_excite u_excite (
            .cur    (q_fb[i]),
            .target (target_c[i]),
            .jk_c   (pair_c)
        );
        assign exc_j_c[i] = pair_c[1];
        assign exc_k_c[i] = pair_c[0];
    end

    // Next-state and next-output logic; all outputs are registered below
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        j_nxt        = j;
        k_nxt        = k;
        expected_nxt = expected;
        en_nxt       = 1'b0;
        done_nxt     = 1'b0;
        fail_nxt     = 1'b0;
        ready_nxt    = 1'b0;

        case (state)
            ST_IDLE: begin
                ready_nxt = 1'b1;
                j_nxt     = '0;
                k_nxt     = '0;
                if (req_valid && req_ready) begin
                    state_nxt    = ST_SETUP;
                    ready_nxt    = 1'b0;
                    j_nxt        = exc_j_c;
                    k_nxt        = exc_k_c;
                    expected_nxt = target_c;
                end
            end
            ST_SETUP: begin
                state_nxt = ST_STROBE;
                en_nxt    = 1'b1;
                cnt_nxt   = '0;
            end
            ST_STROBE: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = ST_HOLD;
                end else begin
                    en_nxt  = 1'b1;
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                state_nxt = ST_CHECK;
                j_nxt     = '0;
                k_nxt     = '0;
                done_nxt  = 1'b1;
                fail_nxt  = (q_fb != expected);
            end
            ST_CHECK: begin
                state_nxt = ST_IDLE;
                ready_nxt = 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
                ready_nxt = 1'b1;
                j_nxt     = '0;
                k_nxt     = '0;
            end
        endcase
    end

    // State and output registers; reset clears en/j/k immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            j         <= '0;
            k         <= '0;
            en        <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            expected  <= '0;
            req_ready <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            j         <= j_nxt;
            k         <= k_nxt;
            en        <= en_nxt;
            done      <= done_nxt;
            fail      <= fail_nxt;
            expected  <= expected_nxt;
            req_ready <= ready_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ((j & k) == '0) else $error("jk_bank_driver: j=k=1 driven");
        end
    end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Directed bench for jk_bank_driver against a behavioural JK latch bank model.
module tb_jk_bank_driver;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned PULSE = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_op;
    logic [WIDTH-1:0] req_data;
    logic             req_ready;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] j, k, expected;
    logic             en, done, fail;

    logic [WIDTH-1:0] q_model;
    logic [WIDTH-1:0] stuck0;
    int               n_checks = 0;
    int               n_pass   = 0;
    int               jk_bad   = 0;

    jk_bank_driver #(.WIDTH(WIDTH), .PULSE(PULSE)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_data  (req_data),
        .req_ready (req_ready),
        .q_fb      (q_fb),
        .j         (j),
        .k         (k),
        .en        (en),
        .done      (done),
        .fail      (fail),
        .expected  (expected)
    );

    always #5 clk = ~clk;

    // Level-sensitive JK latch bank with async clear; stuck0 forces bits of q_fb low
    always @(rst, en, j, k) begin
        if (rst)     q_model = '0;
        else if (en) q_model = (q_model | j) & ~k;
    end
    assign q_fb = q_model & ~stuck0;

    always @(negedge clk) begin
        if ((j & k) != '0) jk_bad++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and observe it for 8 cycles; cycle 1 is SETUP
    task automatic run_req(input logic op, input logic [WIDTH-1:0] data,
                           output logic [WIDTH-1:0] sj, output logic [WIDTH-1:0] sk,
                           output logic [WIDTH-1:0] sexp, output int en_cnt,
                           output int done_at, output logic f,
                           output logic [WIDTH-1:0] qd, output logic [WIDTH-1:0] jk_or);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = data;
        tick();
        req_valid = 1'b0;
        sj = j; sk = k; sexp = expected;
        en_cnt = 0; done_at = 0; f = 1'b0; qd = '0; jk_or = '0;
        for (int c = 1; c <= 8; c++) begin
            if (en) en_cnt++;
            jk_or = jk_or | j | k;
            if (done && done_at == 0) begin
                done_at = c;
                f       = fail;
                qd      = q_fb;
            end
            if (c < 8) tick();
        end
    endtask

    logic [WIDTH-1:0] sj, sk, sexp, qd, jk_or;
    int               en_cnt, done_at, n_done;
    logic             f;

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 1'b0;
        req_data  = '0;
        stuck0    = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_j", j, 0);
        check("rst_k", k, 0);
        check("rst_en", en, 0);
        check("rst_ready", req_ready, 1);
        check("rst_expected", expected, 0);
        check("rst_qfb", q_fb, 0);
        tick();

        // WRITE 0101 from 0000
        run_req(1'b0, 4'b0101, sj, sk, sexp, en_cnt, done_at, f, qd, jk_or);
        check("wr_setup_j", sj, 4'b0101);
        check("wr_setup_k", sk, 4'b0000);
        check("wr_en_cycles", en_cnt, 2);
        check("wr_done_at", done_at, 5);
        check("wr_fail", f, 0);
        check("wr_q", qd, 4'b0101);

        // TOGGLE 1111 from 0101
        run_req(1'b1, 4'b1111, sj, sk, sexp, en_cnt, done_at, f, qd, jk_or);
        check("tg_expected", sexp, 4'b1010);
        check("tg_setup_j", sj, 4'b1010);
        check("tg_setup_k", sk, 4'b0101);
        check("tg_done_at", done_at, 5);
        check("tg_fail", f, 0);
        check("tg_q", qd, 4'b1010);

        // WRITE 1010 with q already 1010
        run_req(1'b0, 4'b1010, sj, sk, sexp, en_cnt, done_at, f, qd, jk_or);
        check("nc_jk_any", jk_or, 0);
        check("nc_en_cycles", en_cnt, 2);
        check("nc_done_at", done_at, 5);
        check("nc_fail", f, 0);

        // Bit 0 stuck low: WRITE 0001 must report fail
        stuck0 = 4'b0001;
        run_req(1'b0, 4'b0001, sj, sk, sexp, en_cnt, done_at, f, qd, jk_or);
        check("flt_setup_j", sj, 4'b0001);
        check("flt_setup_k", sk, 4'b1010);
        check("flt_done_at", done_at, 5);
        check("flt_fail", f, 1);
        run_req(1'b0, 4'b0000, sj, sk, sexp, en_cnt, done_at, f, qd, jk_or);
        check("flt_next_done_at", done_at, 5);
        check("flt_next_fail", f, 0);
        stuck0 = '0;
        run_req(1'b0, 4'b0000, sj, sk, sexp, en_cnt, done_at, f, qd, jk_or);
        check("clr_setup_k", sk, 4'b0001);
        check("clr_fail", f, 0);
        check("clr_q", qd, 4'b0000);

        // req_valid while busy is ignored
        req_valid = 1'b1; req_op = 1'b0; req_data = 4'b0011;
        tick();                      // SETUP
        req_data = 4'b1111;
        tick();                      // STROBE 1, req_valid still high
        check("busy_ready", req_ready, 0);
        check("busy_en", en, 1);
        tick();                      // STROBE 2
        req_valid = 1'b0;
        tick();                      // HOLD
        tick();                      // CHECK
        check("busy_done", done, 1);
        check("busy_fail", fail, 0);
        check("busy_expected", expected, 4'b0011);
        tick();                      // IDLE
        check("busy_ready_after", req_ready, 1);
        tick();
        check("busy_not_queued", req_ready, 1);
        check("busy_expected_kept", expected, 4'b0011);

        // Reset mid-STROBE
        req_valid = 1'b1; req_op = 1'b0; req_data = 4'b1100;
        tick();                      // SETUP
        req_valid = 1'b0;
        tick();                      // STROBE 1
        check("mid_en_before", en, 1);
        rst = 1'b1;
        #1;
        check("mid_en_async", en, 0);
        check("mid_j_async", j, 0);
        check("mid_k_async", k, 0);
        tick();
        rst = 1'b0;
        n_done = 0;
        for (int c = 0; c < 8; c++) begin
            if (done || fail) n_done++;
            tick();
        end
        check("mid_no_done", n_done, 0);
        check("mid_ready", req_ready, 1);
        check("mid_expected", expected, 0);

        check("jk_never_11", jk_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
